// File: rtl/tcs_bist.sv
// rtl/tcs_bist.sv - built-in self test sequencer for a 2-bit cascadable comparator slice
module tcs_bist #(
    parameter int SETTLE = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [1:0] a_o,
    output logic [1:0] b_o,
    output logic       eq_o,
    output logic       gt_o,
    input  logic       EQ_i,
    input  logic       GT_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] err_count,
    output logic [5:0] fail_first
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [7:0] CNT_LAST  = 8'(SETTLE - 1);
    localparam logic [5:0] V_LAST    = 6'd47;
    localparam logic [5:0] NO_FAIL   = 6'h3F;
    localparam logic [5:0] ERR_MAX   = 6'd48;

    logic [1:0] state;
    logic [5:0] v;
    logic [7:0] cnt;
    logic       exp_eq;
    logic       exp_gt;
    logic       mismatch;

    // Stimulus packing {a, b, eq, gt}; mode 1 drives gt-in, mode 2 drives eq-in.
    function automatic logic [5:0] stim(input logic [5:0] idx);
        logic [1:0] casc;
        casc = 2'b00;
        if (idx[5:4] == 2'd1) casc = 2'b01;
        if (idx[5:4] == 2'd2) casc = 2'b10;
        return {idx[3:2], idx[1:0], casc};
    endfunction

    // Stimulus registers hold vector v throughout SETTLE and CHECK.
    assign exp_eq   = eq_o & (a_o == b_o);
    assign exp_gt   = gt_o | (eq_o & (a_o > b_o));
    assign mismatch = ({EQ_i, GT_i} != {exp_eq, exp_gt});

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            v          <= '0;
            cnt        <= '0;
            err_count  <= '0;
            fail_first <= NO_FAIL;
            {a_o, b_o, eq_o, gt_o} <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_SETTLE;
                        v          <= '0;
                        cnt        <= '0;
                        err_count  <= '0;
                        fail_first <= NO_FAIL;
                        {a_o, b_o, eq_o, gt_o} <= stim(6'd0);
                    end
                end
                S_SETTLE: begin
                    if (cnt == CNT_LAST) begin
                        state <= S_CHECK;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        if (err_count != ERR_MAX) err_count <= err_count + 6'd1;
                        if (fail_first == NO_FAIL) fail_first <= v;
                    end
                    if (v == V_LAST) begin
                        state <= S_DONE;
                        {a_o, b_o, eq_o, gt_o} <= '0;
                    end else begin
                        state <= S_SETTLE;
                        v     <= v + 6'd1;
                        cnt   <= '0;
                        {a_o, b_o, eq_o, gt_o} <= stim(v + 6'd1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_SETTLE) || (state == S_CHECK);
    assign done = (state == S_DONE);
    assign pass = done && (err_count == 6'd0);

endmodule

// File: doc/tcs_bist.md
TCS_BIST -- requirements
Module: tcs_bist

Interface
REQ-001 Parameter SETTLE, default 9: cycles each vector is held before its response is sampled; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  begin a test run; sampled only in IDLE or DONE.
REQ-005 a_o  output  2  operand A driven to the comparator slice under test.
REQ-006 b_o  output  2  operand B driven to the comparator slice under test.
REQ-007 eq_o  output  1  cascade equal-in driven to the slice.
REQ-008 gt_o  output  1  cascade greater-in driven to the slice.
REQ-009 EQ_i  input  1  slice equal output (response).
REQ-010 GT_i  input  1  slice greater output (response).
REQ-011 busy  output  1  high while a run is in progress.
REQ-012 done  output  1  high from run completion until the next accepted start or reset.
REQ-013 pass  output  1  high with done when err_count is 0.
REQ-014 err_count  output  6  number of mismatching vectors in the current or last run.
REQ-015 fail_first  output  6  index of the first failing vector; 6'h3F if none.

Function
REQ-016 The block SHALL run 48 vectors with index v = 0..47, where mode = v/16 and {a_o,b_o} = v%16, with a_o in the upper two bits.
REQ-017 The cascade inputs {eq_o,gt_o} SHALL be 00 for mode 0, 01 for mode 1 and 10 for mode 2.
REQ-018 The expected EQ SHALL be eq_o AND (a_o==b_o), and the expected GT SHALL be gt_o OR (eq_o AND a_o>b_o), both using unsigned compares.
REQ-019 The FSM SHALL have the states IDLE, SETTLE, CHECK and DONE, encoded in 2 bits.
REQ-020 IDLE with start=1 SHALL go to SETTLE with v=0, settle counter=0, err_count=0, fail_first=3F and busy=1 on the next cycle.
REQ-021 SETTLE SHALL increment the counter each cycle and go to CHECK when the counter reaches SETTLE-1.
REQ-022 CHECK SHALL compare {EQ_i,GT_i} against the expected value for v during that one cycle.
REQ-023 On a CHECK mismatch, err_count SHALL increment, and fail_first SHALL load v if it is still 3F.
REQ-024 After a CHECK with v<47, the block SHALL set v=v+1, clear the counter and return to SETTLE.
REQ-025 After a CHECK with v=47, the block SHALL go to DONE with busy=0 and done=1.
REQ-026 Each vector SHALL be held for exactly SETTLE+1 cycles, so a run takes 48*(SETTLE+1) cycles from busy rising to done rising (480 for SETTLE=9).
REQ-027 a_o, b_o, eq_o and gt_o SHALL be registered and change only at vector boundaries.
REQ-028 In IDLE and DONE, a_o, b_o, eq_o and gt_o SHALL be driven to 0.
REQ-029 start SHALL be ignored in SETTLE and CHECK.
REQ-030 start=1 in DONE SHALL restart the run exactly as from IDLE, clearing done, err_count and fail_first.
REQ-031 A continuously high start SHALL cause back-to-back runs with one DONE cycle between them.
REQ-032 err_count cannot exceed 48 and SHALL never wrap.
REQ-033 pass SHALL equal done AND (err_count==0).
REQ-034 EQ_i and GT_i SHALL be ignored outside CHECK.

Reset
REQ-035 rst=1 SHALL force IDLE, v=0, counter=0, busy=0, done=0, pass=0, err_count=0, fail_first=3F and all stimulus outputs to 0 on the next edge.
REQ-036 rst SHALL override start and any run in progress, including reset asserted mid-run.
REQ-037 Reset asserted mid-run SHALL discard all partial results.

Verification
REQ-038 Golden comparator slice, start pulse, SETTLE=9 -> done=1 exactly 480 cycles after busy rises, pass=1, err_count=0, fail_first=3F.
REQ-039 Slice with GT stuck at 0 -> err_count=22 (16 in mode 1 plus 6 in mode 2), fail_first=16, pass=0.
REQ-040 Slice with EQ stuck at 1 -> err_count=44 (16+16+12), fail_first=0.
REQ-041 Golden slice, rst pulsed at cycle 200 of a run -> all outputs at reset values on the next cycle; a new start then yields a clean 480-cycle pass.
REQ-042 Golden slice, start held high during a run -> no restart occurs and v advances monotonically 0..47.
REQ-043 Golden slice, start asserted in DONE after a failing run -> err_count and fail_first clear, and the new run passes.
